// File: rtl/execute_mc.sv
// Y86-64 execute stage: ALU, condition codes, cmov/jump condition, store-data forwarding,
// plus a multi-cycle unsigned MUL/DIVU/REMU unit (radix-2, one bit per cycle).
// Single-cycle ops are combinational; multi-cycle ops stall for XLEN+1 cycles, result shows in DONE.
module execute_mc #(
  parameter int         XLEN      = 64,
  parameter bit         MULDIV_EN = 1'b1,
  parameter logic [2:0] CC_RST    = 3'b100
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [3:0]      E_icode_i,
  input  logic [3:0]      E_ifun_i,
  input  logic [XLEN-1:0] E_valC_i,
  input  logic [XLEN-1:0] E_valA_i,
  input  logic [XLEN-1:0] E_valB_i,
  input  logic [3:0]      E_dstE_i,
  input  logic [3:0]      E_dstM_i,
  input  logic [3:0]      E_srcA_i,
  input  logic [3:0]      M_dstM_i,
  input  logic [XLEN-1:0] m_valM_i,
  input  logic [2:0]      m_stat_i,
  input  logic [2:0]      W_stat_i,
  output logic            e_Cnd_o,
  output logic [XLEN-1:0] e_valA_o,
  output logic [XLEN-1:0] e_valE_o,
  output logic [3:0]      e_dstE_o,
  output logic [3:0]      e_dstM_o,
  output logic            e_stall_o
);
  localparam logic [3:0] I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3, I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ = 4'h6, I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
  localparam logic [3:0] F_ADD = 4'h0, F_SUB = 4'h1, F_AND = 4'h2, F_XOR = 4'h3;
  localparam logic [3:0] F_MUL = 4'h4, F_DIVU = 4'h5, F_REMU = 4'h6;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [2:0] SADR = 3'd2, SINS = 3'd3, SHLT = 3'd4;
  localparam logic [XLEN-1:0] STEP = XLEN'(XLEN / 8);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state_q;
  logic [6:0]          cnt_q;
  logic [XLEN-1:0]     opa_q;      // multiplicand / divisor (valA)
  logic [2*XLEN-1:0]   acc_q;      // MUL: {hi, lo/multiplier}; DIV: {remainder, quotient/dividend}
  logic [3:0]          fun_q;
  logic [2:0]          cc_q;       // {ZF, SF, OF}

  logic [XLEN-1:0] alu_a, alu_b, alu_res, md_res, val_e;
  logic [3:0]      alu_fun;
  logic            alu_of, md_of, of_new, md_fun, md_start, exc, cc_we;
  logic [XLEN:0]   mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign exc = (m_stat_i == SADR) || (m_stat_i == SINS) || (m_stat_i == SHLT) ||
               (W_stat_i == SADR) || (W_stat_i == SINS) || (W_stat_i == SHLT);
  assign md_fun   = MULDIV_EN && (E_ifun_i >= F_MUL) && (E_ifun_i <= F_REMU);
  assign md_start = (state_q == S_IDLE) && (E_icode_i == I_OPQ) && md_fun;
  // Reset forces the stall low even while a multi-cycle op is still presented.
  assign e_stall_o = !rst_i && (md_start || (state_q == S_BUSY));

  // Operand and function selection for the single-cycle ALU (B op A).
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (E_icode_i)
      I_RRMOVQ, I_OPQ:            alu_a = E_valA_i;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC_i;
      I_CALL, I_PUSHQ:            alu_a = '0 - STEP;
      I_RET, I_POPQ:              alu_a = STEP;
      default:                    alu_a = '0;
    endcase
    case (E_icode_i)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = E_valB_i;
      default:                                                   alu_b = '0;
    endcase
    alu_fun = (E_icode_i == I_OPQ) ? E_ifun_i : F_ADD;
  end

  // Single-cycle ALU; ifun values outside the basic four (incl. MUL/DIV with MULDIV_EN=0) add.
  always_comb begin
    alu_res = alu_b + alu_a;
    alu_of  = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (alu_res[XLEN-1] != alu_a[XLEN-1]);
    case (alu_fun)
      F_SUB: begin
        alu_res = alu_b - alu_a;
        alu_of  = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (alu_res[XLEN-1] != alu_b[XLEN-1]);
      end
      F_AND: begin alu_res = alu_b & alu_a; alu_of = 1'b0; end
      F_XOR: begin alu_res = alu_b ^ alu_a; alu_of = 1'b0; end
      default: ;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide; divisor 0 naturally yields
  // an all-ones quotient and leaves the dividend in the remainder.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = rem_sh - {1'b0, opa_q};
    div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    md_res   = (fun_q == F_REMU) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    md_of    = (fun_q == F_MUL) && (acc_q[2*XLEN-1:XLEN] != '0);
  end

  // Result mux, new condition codes and the write enable.
  always_comb begin
    val_e  = (state_q == S_DONE) ? md_res : alu_res;
    of_new = (state_q == S_DONE) ? md_of  : alu_of;
    cc_we  = (E_icode_i == I_OPQ) && !exc &&
             (((state_q == S_IDLE) && !md_start) || (state_q == S_DONE));
  end

  // Multi-cycle FSM: latch operands on start, iterate XLEN times, present result for one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      acc_q   <= '0;
      fun_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (md_start) begin
          opa_q   <= E_valA_i;
          acc_q   <= {{XLEN{1'b0}}, E_valB_i};
          fun_q   <= E_ifun_i;
          cnt_q   <= 7'(XLEN);
          state_q <= S_BUSY;
        end
        S_BUSY: if (exc) begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end else begin
          acc_q <= (fun_q == F_MUL) ? mul_next : div_next;
          cnt_q <= cnt_q - 7'd1;
          if (cnt_q == 7'd1) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Condition-code register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      cc_q <= CC_RST;
    else if (cc_we) cc_q <= {(val_e == '0), val_e[XLEN-1], of_new};
  end

  // Branch / cmov condition from the current condition codes.
  always_comb begin
    case (E_ifun_i)
      4'd0:    e_Cnd_o = 1'b1;
      4'd1:    e_Cnd_o = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      4'd2:    e_Cnd_o = cc_q[1] ^ cc_q[0];
      4'd3:    e_Cnd_o = cc_q[2];
      4'd4:    e_Cnd_o = !cc_q[2];
      4'd5:    e_Cnd_o = !(cc_q[1] ^ cc_q[0]);
      4'd6:    e_Cnd_o = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
      default: e_Cnd_o = 1'b0;
    endcase
  end

  assign e_valE_o = val_e;
  assign e_valA_o = (((E_icode_i == I_RMMOVQ) || (E_icode_i == I_PUSHQ)) && (E_srcA_i == M_dstM_i))
                    ? m_valM_i : E_valA_i;
  assign e_dstE_o = ((E_icode_i == I_RRMOVQ) && !e_Cnd_o) ? RNONE : E_dstE_i;
  assign e_dstM_o = E_dstM_i;
endmodule

// File: tb/tb_execute_mc.sv
// Directed bench for execute_mc (XLEN=64): ALU/CC/Cnd, multi-cycle MUL/DIVU/REMU latency
// and results, status gating, reset during a busy op, forwarding and cmov destination squash.
module tb_execute_mc;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode, ifun, dstE, dstM, srcA, M_dstM;
  logic [63:0] valC, valA, valB, m_valM;
  logic [2:0]  m_stat, W_stat;
  logic        e_Cnd, e_stall;
  logic [63:0] e_valA, e_valE;
  logic [3:0]  e_dstE, e_dstM;

  int checks = 0;
  int fails  = 0;

  execute_mc #(.XLEN(64), .MULDIV_EN(1'b1), .CC_RST(3'b100)) dut (
    .clk_i(clk), .rst_i(rst),
    .E_icode_i(icode), .E_ifun_i(ifun), .E_valC_i(valC), .E_valA_i(valA), .E_valB_i(valB),
    .E_dstE_i(dstE), .E_dstM_i(dstM), .E_srcA_i(srcA), .M_dstM_i(M_dstM), .m_valM_i(m_valM),
    .m_stat_i(m_stat), .W_stat_i(W_stat),
    .e_Cnd_o(e_Cnd), .e_valA_o(e_valA), .e_valE_o(e_valE),
    .e_dstE_o(e_dstE), .e_dstM_o(e_dstM), .e_stall_o(e_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b);
    icode = ic; ifun = fn; valA = a; valB = b;
  endtask

  // Present a multi-cycle op, count stall cycles, check DONE result and the CC one cycle later.
  task automatic run_md(input string tag, input logic [3:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_v, input logic [2:0] exp_cc);
    int n;
    n = 0;
    @(negedge clk);
    set_op(4'h6, fn, a, b);
    for (int i = 0; i < 200; i++) begin
      #1;
      if (!e_stall) break;
      n++;
      @(negedge clk);
    end
    chk({tag, "_stall_cycles"}, 64'(n), 64'd65);
    chk({tag, "_valE"}, e_valE, exp_v);
    @(negedge clk);
    set_op(4'h1, 4'h0, 64'd0, 64'd0);
    #1;
    chk({tag, "_cc"}, 64'(dut.cc_q), 64'(exp_cc));
  endtask

  initial begin
    rst = 1'b1; icode = 4'h1; ifun = 4'h0; valC = '0; valA = '0; valB = '0;
    dstE = 4'h5; dstM = 4'hF; srcA = 4'h0; M_dstM = 4'hF; m_valM = '0;
    m_stat = 3'd1; W_stat = 3'd1;
    #1;
    chk("rst_stall", 64'(e_stall), 64'd0);
    chk("rst_cc", 64'(dut.cc_q), 64'(3'b100));
    @(negedge clk); rst = 1'b0;

    // ADD overflow: result negative with OF set
    @(negedge clk); set_op(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF);
    #1; chk("add_ovf_valE", e_valE, 64'h8000_0000_0000_0000);
    chk("add_ovf_stall", 64'(e_stall), 64'd0);
    @(negedge clk); set_op(4'h2, 4'h2, 64'd0, 64'd0);
    #1; chk("add_ovf_cc", 64'(dut.cc_q), 64'(3'b011));
    // SF=1 and OF=1 agree, so "less" is false and the cmov destination is squashed
    chk("cmovl_cnd", 64'(e_Cnd), 64'd0);
    chk("cmovl_dstE", 64'(e_dstE), 64'hF);
    ifun = 4'h6;
    #1; chk("cmovg_cnd", 64'(e_Cnd), 64'd1);
    // stack pointer step
    set_op(4'hA, 4'h0, 64'd0, 64'h100);
    #1; chk("push_valE", e_valE, 64'hF8);
    set_op(4'hB, 4'h0, 64'd0, 64'h100);
    #1; chk("pop_valE", e_valE, 64'h108);

    run_md("mul_3x5", 4'h4, 64'd3, 64'd5, 64'd15, 3'b000);
    run_md("mul_ovf", 4'h4, 64'd2, 64'h8000_0000_0000_0000, 64'd0, 3'b101);
    run_md("divu_100_7", 4'h5, 64'd7, 64'd100, 64'd14, 3'b000);
    run_md("remu_100_7", 4'h6, 64'd7, 64'd100, 64'd2, 3'b000);
    run_md("divu_by0", 4'h5, 64'd0, 64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010);
    run_md("remu_by0", 4'h6, 64'd0, 64'd100, 64'd100, 3'b000);

    // Downstream exception while busy aborts the op
    @(negedge clk); set_op(4'h6, 4'h4, 64'd9, 64'd9);
    repeat (5) @(negedge clk);
    m_stat = 3'd2; set_op(4'h1, 4'h0, 64'd0, 64'd0);
    @(negedge clk); m_stat = 3'd1;
    #1; chk("abort_stall", 64'(e_stall), 64'd0);
    chk("abort_cc", 64'(dut.cc_q), 64'(3'b000));

    // Reset during BUSY cycle 10 of a MUL
    @(negedge clk); set_op(4'h6, 4'h4, 64'd3, 64'd5);
    repeat (10) @(negedge clk);
    #1; chk("busy_stall", 64'(e_stall), 64'd1);
    rst = 1'b1;
    #1; chk("midrst_stall", 64'(e_stall), 64'd0);
    chk("midrst_cc", 64'(dut.cc_q), 64'(3'b100));
    @(negedge clk); rst = 1'b0; set_op(4'h1, 4'h0, 64'd0, 64'd0);
    run_md("mul_7x6", 4'h4, 64'd7, 64'd6, 64'd42, 3'b000);

    // SUB gated by exceptional status, then allowed
    @(negedge clk); m_stat = 3'd2; set_op(4'h6, 4'h1, 64'd5, 64'd5);
    #1; chk("sub_sadr_valE", e_valE, 64'd0);
    @(negedge clk); m_stat = 3'd1; set_op(4'h1, 4'h0, 64'd0, 64'd0);
    #1; chk("sub_sadr_cc", 64'(dut.cc_q), 64'(3'b000));
    @(negedge clk); set_op(4'h6, 4'h1, 64'd5, 64'd5);
    @(negedge clk); set_op(4'h1, 4'h0, 64'd0, 64'd0);
    #1; chk("sub_aok_cc", 64'(dut.cc_q), 64'(3'b100));

    // Store-data forwarding
    @(negedge clk); set_op(4'h4, 4'h0, 64'h55, 64'h1000);
    valC = 64'h10; srcA = 4'h3; M_dstM = 4'h3; m_valM = 64'hAB; dstM = 4'h7;
    #1; chk("rmmovq_fwd", e_valA, 64'hAB);
    chk("rmmovq_valE", e_valE, 64'h1010);
    chk("dstM_pass", 64'(e_dstM), 64'h7);
    srcA = 4'h4;
    #1; chk("rmmovq_nofwd", e_valA, 64'h55);

    // Clear ZF, then cmove squashes and cmovne keeps the destination
    set_op(4'h6, 4'h0, 64'd1, 64'd1);
    @(negedge clk); set_op(4'h2, 4'h3, 64'd0, 64'd0);
    #1; chk("add_cc", 64'(dut.cc_q), 64'(3'b000));
    chk("cmove_dstE", 64'(e_dstE), 64'hF);
    ifun = 4'h4;
    #1; chk("cmovne_dstE", 64'(e_dstE), 64'h5);
    chk("cmovne_cnd", 64'(e_Cnd), 64'd1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
